// File: rtl/dii_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : dii_pkg                                                    |
// | Purpose  : Shared DII packet constants, flag field positions, type    |
// |            encoding and receive-side state enumeration.               |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package dii_pkg;

  // Flit width of the DII channel
  localparam int unsigned c_flit_w = 16;

  // Position of each header word within a packet
  localparam int unsigned c_hdr_dest_idx  = 0;
  localparam int unsigned c_hdr_src_idx   = 1;
  localparam int unsigned c_hdr_flags_idx = 2;
  localparam int unsigned c_hdr_words     = 3;

  // Bit fields inside the flags header word
  localparam int unsigned c_type_msb     = 15;
  localparam int unsigned c_type_lsb     = 14;
  localparam int unsigned c_type_sub_msb = 13;
  localparam int unsigned c_type_sub_lsb = 10;

  // Packet type encoding, shared with the transmit-side packetizer
  typedef enum logic [1:0] {
    DII_TYPE_REG   = 2'd0,
    DII_TYPE_PLAIN = 2'd1,
    DII_TYPE_EVENT = 2'd2,
    DII_TYPE_RSVD  = 2'd3
  } dii_type_e;

  // Receiver state: which word the next accepted flit is, or holding a packet
  typedef enum logic [2:0] {
    RX_DEST    = 3'd0,
    RX_SRC     = 3'd1,
    RX_FLAGS   = 3'd2,
    RX_PAYLOAD = 3'd3,
    RX_HOLD    = 3'd4
  } rx_state_e;

endpackage : dii_pkg
`default_nettype wire

// File: rtl/dii_packet_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dii_packet_rx                                              |
// | Purpose  : DII slave-side sink. Accepts 16-bit flits, parses the      |
// |            three header words, buffers up to MAX_PAYLOAD payload      |
// |            words and presents one whole packet behind valid/ready.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module dii_packet_rx
  import dii_pkg::*;
#(
  parameter  int unsigned MAX_PAYLOAD = 8,
  parameter  int unsigned DROP_CNT_W  = 8,
  localparam int unsigned LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 dii_in_data,
  input  logic                        dii_in_last,
  input  logic                        dii_in_valid,
  output logic                        dii_in_ready,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic [15:0]                 pkt_dest,
  output logic [15:0]                 pkt_src,
  output logic [1:0]                  pkt_type,
  output logic [3:0]                  pkt_type_sub,
  output logic [LEN_W-1:0]            pkt_len,
  output logic [16*MAX_PAYLOAD-1:0]   pkt_payload,
  output logic                        pkt_overflow,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);

  localparam logic [DROP_CNT_W-1:0] c_drop_max = '1;
  localparam logic [LEN_W-1:0]      c_len_max  = LEN_W'(MAX_PAYLOAD);

  rx_state_e               r_state;
  rx_state_e               w_next_state;
  logic                    w_accept;
  logic [15:0]             r_dest;
  logic [15:0]             r_src;
  dii_type_e               r_type;
  logic [3:0]              r_type_sub;
  logic [LEN_W-1:0]        r_len;
  logic                    r_overflow;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [c_flit_w-1:0]     r_payload [MAX_PAYLOAD];

  assign w_accept = dii_in_valid & dii_in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RX_DEST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; handshake outputs decode the registered state only
  always_comb begin
    w_next_state = r_state;
    dii_in_ready = (r_state != RX_HOLD);
    pkt_valid    = (r_state == RX_HOLD);
    case (r_state)
      RX_DEST: begin
        // A last flit here is a one-word runt: stay put for the next packet
        if (w_accept && !dii_in_last) w_next_state = RX_SRC;
      end
      RX_SRC: begin
        if (w_accept) w_next_state = dii_in_last ? RX_DEST : RX_FLAGS;
      end
      RX_FLAGS: begin
        if (w_accept) w_next_state = dii_in_last ? RX_HOLD : RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        if (w_accept && dii_in_last) w_next_state = RX_HOLD;
      end
      RX_HOLD: begin
        if (pkt_ready) w_next_state = RX_DEST;
      end
      default: w_next_state = RX_DEST;
    endcase
  end

  // Header capture, length/overflow tracking and runt counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest     <= '0;
      r_src      <= '0;
      r_type     <= DII_TYPE_REG;
      r_type_sub <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        RX_DEST: begin
          r_dest <= dii_in_data;
          if (dii_in_last && (r_drop_cnt != c_drop_max)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
          end
        end
        RX_SRC: begin
          r_src <= dii_in_data;
          if (dii_in_last && (r_drop_cnt != c_drop_max)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
          end
        end
        RX_FLAGS: begin
          r_type     <= dii_type_e'(dii_in_data[c_type_msb:c_type_lsb]);
          r_type_sub <= dii_in_data[c_type_sub_msb:c_type_sub_lsb];
          r_len      <= '0;
          r_overflow <= 1'b0;
        end
        RX_PAYLOAD: begin
          if (r_len < c_len_max) begin
            r_len <= r_len + LEN_W'(1);
          end else begin
            r_overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload buffer write at index r_len; words beyond capacity match no slot
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == RX_PAYLOAD)) begin
      for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
        if (r_len == LEN_W'(i)) r_payload[i] <= dii_in_data;
      end
    end
  end

  generate
    for (genvar g = 0; g < int'(MAX_PAYLOAD); g++) begin : g_payload_out
      assign pkt_payload[16*g +: 16] = r_payload[g];
    end
  endgenerate

  assign pkt_dest     = r_dest;
  assign pkt_src      = r_src;
  assign pkt_type     = r_type;
  assign pkt_type_sub = r_type_sub;
  assign pkt_len      = r_len;
  assign pkt_overflow = r_overflow;
  assign drop_cnt     = r_drop_cnt;

endmodule : dii_packet_rx
`default_nettype wire

// File: tb/tb_dii_packet_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_dii_packet_rx                                           |
// | Purpose  : Self-checking bench for dii_packet_rx. Packets are checked |
// |            against a packet-level reference model.                    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_dii_packet_rx;

  localparam int MAXP     = 8;
  localparam int DW       = 8;
  localparam int LW       = $clog2(MAXP + 1);
  localparam int DROP_MAX = (1 << DW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       dii_in_data;
  logic              dii_in_last;
  logic              dii_in_valid;
  logic              dii_in_ready;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [15:0]       pkt_dest;
  logic [15:0]       pkt_src;
  logic [1:0]        pkt_type;
  logic [3:0]        pkt_type_sub;
  logic [LW-1:0]     pkt_len;
  logic [16*MAXP-1:0] pkt_payload;
  logic              pkt_overflow;
  logic [DW-1:0]     drop_cnt;

  int total = 0;
  int bad   = 0;
  int model_drop = 0;

  dii_packet_rx #(.MAX_PAYLOAD(MAXP), .DROP_CNT_W(DW)) dut (
    .clk(clk), .rst(rst),
    .dii_in_data(dii_in_data), .dii_in_last(dii_in_last),
    .dii_in_valid(dii_in_valid), .dii_in_ready(dii_in_ready),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dest(pkt_dest), .pkt_src(pkt_src),
    .pkt_type(pkt_type), .pkt_type_sub(pkt_type_sub),
    .pkt_len(pkt_len), .pkt_payload(pkt_payload),
    .pkt_overflow(pkt_overflow), .drop_cnt(drop_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Idle cycles with garbage on the data lines; must have no effect
  task automatic idle_gap();
    int g;
    g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    repeat (g) begin
      dii_in_valid = 1'b0;
      dii_in_data  = 16'($urandom);
      dii_in_last  = 1'($urandom);
      @(negedge clk);
    end
  endtask

  // Present one flit at a negedge; returns at the negedge after acceptance
  task automatic send_flit(input logic [15:0] d, input bit l);
    int n = 0;
    dii_in_valid = 1'b1;
    dii_in_data  = d;
    dii_in_last  = l;
    while (dii_in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (dii_in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL flit_accept: dii_in_ready=%b after %0d cycles, required 1", dii_in_ready, n);
    end
    @(negedge clk);
    dii_in_valid = 1'b0;
    dii_in_data  = 16'($urandom);
    dii_in_last  = 1'($urandom);
  endtask

  // Send a whole packet and check the result against the packet-level model
  task automatic run_packet(input logic [15:0] w[$], input int hold, input bit gaps);
    int n, plen;
    bit eovf, ok;
    logic [15:0] ed, es, ef;
    n = w.size();
    pkt_ready = 1'($urandom);   // pkt_ready while nothing is held must be ignored
    for (int i = 0; i < n; i++) begin
      if (gaps) idle_gap();
      send_flit(w[i], (i == n - 1));
    end
    pkt_ready = (hold == 0);
    if (n < 3) begin
      if (model_drop < DROP_MAX) model_drop++;
      total++;
      if (pkt_valid !== 1'b0) begin
        bad++; $display("FAIL runt_valid: pkt_valid=%b required 0", pkt_valid);
      end
      total++;
      if (drop_cnt !== DW'(model_drop)) begin
        bad++; $display("FAIL runt_drop_cnt: got %0d required %0d", drop_cnt, model_drop);
      end
      pkt_ready = 1'b0;
      return;
    end
    ed = w[0]; es = w[1]; ef = w[2];
    plen = (n - 3 > MAXP) ? MAXP : n - 3;
    eovf = (n - 3 > MAXP);
    total++;
    if (pkt_valid !== 1'b1 || dii_in_ready !== 1'b0) begin
      bad++; $display("FAIL latency: pkt_valid=%b dii_in_ready=%b required 1/0", pkt_valid, dii_in_ready);
    end
    total++;
    if (pkt_dest !== ed) begin bad++; $display("FAIL dest: got %h required %h", pkt_dest, ed); end
    total++;
    if (pkt_src !== es) begin bad++; $display("FAIL src: got %h required %h", pkt_src, es); end
    total++;
    if (pkt_type !== ef[15:14]) begin bad++; $display("FAIL type: got %0d required %0d", pkt_type, ef[15:14]); end
    total++;
    if (pkt_type_sub !== ef[13:10]) begin bad++; $display("FAIL type_sub: got %0d required %0d", pkt_type_sub, ef[13:10]); end
    total++;
    if (pkt_len !== LW'(plen)) begin bad++; $display("FAIL len: got %0d required %0d", pkt_len, plen); end
    total++;
    if (pkt_overflow !== eovf) begin bad++; $display("FAIL overflow: got %b required %b", pkt_overflow, eovf); end
    total++;
    if (drop_cnt !== DW'(model_drop)) begin bad++; $display("FAIL pkt_drop_cnt: got %0d required %0d", drop_cnt, model_drop); end
    for (int i = 0; i < plen; i++) begin
      total++;
      if (pkt_payload[16*i +: 16] !== w[3+i]) begin
        bad++; $display("FAIL payload[%0d]: got %h required %h", i, pkt_payload[16*i +: 16], w[3+i]);
      end
    end
    // Consumer stalls: everything must stay put and the input stays blocked
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == hold - 1) pkt_ready = 1'b1;
      ok = (pkt_valid === 1'b1) && (dii_in_ready === 1'b0) && (pkt_dest === ed) &&
           (pkt_src === es) && (pkt_type === ef[15:14]) && (pkt_type_sub === ef[13:10]) &&
           (pkt_len === LW'(plen)) && (pkt_overflow === eovf);
      for (int i = 0; i < plen; i++) ok = ok && (pkt_payload[16*i +: 16] === w[3+i]);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL hold_stable: cycle %0d valid=%b ready=%b dest=%h src=%h len=%0d required valid=1 ready=0 dest=%h src=%h len=%0d",
                 h, pkt_valid, dii_in_ready, pkt_dest, pkt_src, pkt_len, ed, es, plen);
      end
    end
    @(negedge clk);
    pkt_ready = 1'b0;
    total++;
    if (pkt_valid !== 1'b0 || dii_in_ready !== 1'b1) begin
      bad++; $display("FAIL release: pkt_valid=%b dii_in_ready=%b required 0/1", pkt_valid, dii_in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dii_in_valid = 1'b0; dii_in_data = '0; dii_in_last = 1'b0; pkt_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_drop = 0;
    total++; if (dii_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b required 1", dii_in_ready); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", pkt_valid); end
    total++; if (pkt_len !== '0) begin bad++; $display("FAIL rst_len: got %0d required 0", pkt_len); end
    total++; if (pkt_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b required 0", pkt_overflow); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL rst_drop_cnt: got %0d required 0", drop_cnt); end
    total++; if (pkt_dest !== '0) begin bad++; $display("FAIL rst_dest: got %h required 0", pkt_dest); end
    total++; if (pkt_src !== '0) begin bad++; $display("FAIL rst_src: got %h required 0", pkt_src); end
    total++; if (pkt_type !== '0) begin bad++; $display("FAIL rst_type: got %0d required 0", pkt_type); end
    total++; if (pkt_type_sub !== '0) begin bad++; $display("FAIL rst_type_sub: got %0d required 0", pkt_type_sub); end
  endtask

  task automatic test_rst_mid_packet();
    logic [15:0] q[$];
    q = {16'h1234, 16'h5678, 16'h0400, 16'h1111, 16'h2222};
    foreach (q[i]) send_flit(q[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_drop = 0;
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b required 0", pkt_valid); end
    total++; if (dii_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b required 1", dii_in_ready); end
    total++; if (drop_cnt !== DW'(0)) begin bad++; $display("FAIL midrst_drop_cnt: got %0d required 0", drop_cnt); end
    q = {16'h00C0, 16'h00D0, 16'h4800, 16'hCAFE};
    run_packet(q, 1, 1'b0);
  endtask

  task automatic test_minimal();
    logic [15:0] q[$];
    q = {16'h0005, 16'h0001, 16'h4000};
    run_packet(q, 0, 1'b0);
  endtask

  task automatic test_hold_stable();
    logic [15:0] q[$];
    q = {16'h0003, 16'h0007, 16'h8C00, 16'hAAAA, 16'hBBBB};
    run_packet(q, 4, 1'b0);
  endtask

  task automatic test_overflow();
    logic [15:0] q[$];
    q = {16'h0010, 16'h0020, 16'h0800};
    for (int i = 0; i < 10; i++) q.push_back(16'(i));
    run_packet(q, 2, 1'b0);
    q = {16'h0011, 16'h0021, 16'hC000, 16'h7777};
    run_packet(q, 0, 1'b0);
  endtask

  task automatic test_runts();
    logic [15:0] q[$];
    int start;
    start = model_drop;
    q = {16'h0101};
    run_packet(q, 0, 1'b0);
    q = {16'h0202, 16'h0303};
    run_packet(q, 0, 1'b0);
    total++;
    if (drop_cnt !== DW'(start + 2)) begin
      bad++; $display("FAIL runt_pair: drop_cnt=%0d required %0d", drop_cnt, start + 2);
    end
    q = {16'h0A0A, 16'h0B0B, 16'h4400};
    run_packet(q, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    int n;
    for (int p = 0; p < 40; p++) begin
      q = {};
      n = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 3 + MAXP + 3));
      for (int i = 0; i < n; i++) q.push_back(16'($urandom));
      run_packet(q, int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] q[$];
    for (int i = 0; i < 300; i++) begin
      q = {16'($urandom)};
      run_packet(q, 0, 1'b0);
    end
    total++;
    if (drop_cnt !== DW'(DROP_MAX)) begin
      bad++; $display("FAIL saturate: drop_cnt=%0d required %0d", drop_cnt, DROP_MAX);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_drop = 0;
    total++;
    if (drop_cnt !== DW'(0)) begin
      bad++; $display("FAIL sat_reset: drop_cnt=%0d required 0", drop_cnt);
    end
  endtask

  // Test sequence
  initial begin
    rst = 1'b1;
    dii_in_valid = 1'b0; dii_in_data = '0; dii_in_last = 1'b0; pkt_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rst_mid_packet();
    test_minimal();
    test_hold_stable();
    test_overflow();
    test_runts();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dii_packet_rx
`default_nettype wire
